// File: rtl/rotn_cipher_fifo.sv
// Nibble-loaded character queue with programmable Caesar rotation.
// Bytes are staged over a 4-bit bus, queued, and rotated on pop.
module rotn_cipher_fifo #(
    parameter int DEPTH         = 4,
    parameter int DEFAULT_SHIFT = 13,
    parameter bit PASS_NONALPHA = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ctl,
    input  logic [3:0] data_in,
    output logic [7:0] data_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [3:0] OP_PUSH   = 4'd0;
    localparam logic [3:0] OP_SETKEY = 4'd1;
    localparam logic [3:0] OP_ENC    = 4'd2;
    localparam logic [3:0] OP_DEC    = 4'd3;
    localparam logic [3:0] OP_POP    = 4'd4;
    localparam logic [3:0] OP_STATUS = 4'd5;
    localparam logic [3:0] OP_COUNT  = 4'd6;
    localparam logic [3:0] OP_CLEAR  = 4'd7;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [7:0]    staged;
    logic [4:0]    shift;
    logic          mode;
    logic          ovf;
    logic          udf;
    logic          key_err;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic [4:0]    rot_amt;
    logic [7:0]    pop_byte;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Letters keep bits [7:5]; only the 1-based letter index rotates.
    function automatic logic [7:0] xform(input logic [7:0] c,
                                         input logic [4:0] r);
        logic [5:0] sum;
        logic       alpha;
        alpha = (c >= 8'h41 && c <= 8'h5A) ||
                (c >= 8'h61 && c <= 8'h7A);
        sum = {1'b0, c[4:0]} - 6'd1 + {1'b0, r};
        if (sum >= 6'd26)
            sum = sum - 6'd26;
        if (alpha)
            return {c[7:5], 5'(sum + 6'd1)};
        else if (PASS_NONALPHA)
            return c;
        else
            return 8'h00;
    endfunction

    // Flags, rotation amount and the rotated head byte.
    always_comb begin
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        push_ok  = (ctl == 2'b10) && (data_in == OP_PUSH) && !full;
        rot_amt  = shift;
        if (mode)
            rot_amt = (shift == 5'd0) ? 5'd0 : 5'(5'd26 - shift);
        pop_byte = xform(mem[rd_ptr], rot_amt);
    end

    // Queue storage; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (!reset && push_ok)
            mem[wr_ptr] <= staged;
    end

    // Control, pointers, key/mode registers and the response byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= 8'h00;
            staged   <= 8'h00;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            shift    <= 5'(DEFAULT_SHIFT);
            mode     <= 1'b0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
            key_err  <= 1'b0;
        end else begin
            unique case (ctl)
                2'b00: begin
                    staged[3:0] <= data_in;
                    data_out    <= 8'h0F;
                end
                2'b01: begin
                    staged[7:4] <= data_in;
                    data_out    <= 8'hF0;
                end
                2'b10: begin
                    case (data_in)
                        OP_PUSH: begin
                            if (!full) begin
                                wr_ptr   <= ptr_next(wr_ptr);
                                count    <= count + 1'b1;
                                data_out <= 8'hAC;
                            end else begin
                                ovf      <= 1'b1;
                                data_out <= 8'hEE;
                            end
                        end
                        OP_SETKEY: begin
                            if (staged < 8'd26) begin
                                shift    <= staged[4:0];
                                data_out <= staged;
                            end else begin
                                key_err  <= 1'b1;
                                data_out <= 8'hEE;
                            end
                        end
                        OP_ENC: begin
                            mode     <= 1'b0;
                            data_out <= 8'hE0;
                        end
                        OP_DEC: begin
                            mode     <= 1'b1;
                            data_out <= 8'hD0;
                        end
                        OP_POP: begin
                            if (!empty) begin
                                rd_ptr   <= ptr_next(rd_ptr);
                                count    <= count - 1'b1;
                                data_out <= pop_byte;
                            end else begin
                                udf      <= 1'b1;
                                data_out <= 8'h00;
                            end
                        end
                        OP_STATUS: data_out <= {ovf, udf, key_err, mode,
                                                full, empty, 2'b00};
                        OP_COUNT:  data_out <= 8'(count);
                        OP_CLEAR: begin
                            ovf      <= 1'b0;
                            udf      <= 1'b0;
                            key_err  <= 1'b0;
                            data_out <= 8'hC1;
                        end
                        default:   data_out <= 8'hFF;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rotn_cipher_fifo.md
Name: rotn_cipher_fifo

Overview:
- Successor to the fixed ROT13 nibble-loaded translator.
- Bytes are still entered as two nibbles over a 4-bit bus.
- Characters are queued in a parametrised FIFO and popped through a Caesar rotation with a programmable shift and an encrypt/decrypt mode.
- Core sits behind the 8-bit io_in/io_out tile wrapper: clk=io_in[0], reset=io_in[1], ctl=io_in[3:2], data_in=io_in[7:4], data_out=io_out.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- DEFAULT_SHIFT, 13, rotation amount after reset; 0..25.
- PASS_NONALPHA, 1, 1 = non-letters pass unchanged on pop; 0 = non-letters pop as 8'h00.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ctl  input  2  00 = load low nibble, 01 = load high nibble, 10 = command (opcode on data_in), 11 = hold.
- data_in  input  4  nibble data, or command opcode when ctl=10.
- data_out  output  8  registered response/data byte.

Behaviour:
- Reset (synchronous, when reset=1 at a clk edge) overrides everything:
  - data_out=8'h00, staged byte=8'h00, FIFO empty.
  - shift=DEFAULT_SHIFT, mode=encrypt.
  - Sticky flags ovf/udf/key_err cleared.
- Reset mid-operation discards FIFO contents.
- All responses appear on data_out one cycle after the ctl/data_in sample and hold until the next non-hold cycle.
- ctl=00: staged[3:0]<=data_in; data_out<=8'h0F.
- ctl=01: staged[7:4]<=data_in; data_out<=8'hF0.
- ctl=11: no state change; data_out holds.
- ctl=10 commands, by data_in opcode:
  - 0 PUSH:
    - Not full: write staged to tail; data_out<=8'hAC.
    - Full: byte dropped, ovf<=1, data_out<=8'hEE.
    - Staged byte is retained after either outcome.
  - 1 SETKEY:
    - staged<26: shift<=staged; data_out<=staged.
    - Else: key_err<=1, shift unchanged, data_out<=8'hEE.
  - 2: mode<=encrypt; data_out<=8'hE0.
  - 3: mode<=decrypt; data_out<=8'hD0.
  - 4 POP:
    - Not empty: remove head; data_out<=transform(head).
    - Empty: udf<=1, data_out<=8'h00, pointers unchanged.
  - 5 STATUS: data_out<={ovf,udf,key_err,mode,full,empty,2'b00}; mode bit 1 = decrypt.
  - 6 COUNT: data_out<=occupancy, zero-extended to 8 bits.
  - 7 CLEAR: ovf/udf/key_err<=0; data_out<=8'hC1.
  - 8..15: no-op; data_out<=8'hFF.
- Transform, evaluated at pop time with the current shift and mode, not the mode/shift at push time:
  - Rotation r = shift (encrypt) or (26-shift) mod 26 (decrypt).
  - 'A'..'Z' (8'h41..8'h5A): 8'h41 + ((c-8'h41+r) mod 26).
  - 'a'..'z' (8'h61..8'h7A): same form with base 8'h61.
  - Any other byte: c if PASS_NONALPHA=1, else 8'h00.
  - Mod-26 arithmetic is done in at least 6 bits; no carry into bit 5, so case is preserved.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy counter of width clog2(DEPTH)+1.
  - Pointers wrap from DEPTH-1 to 0.
  - full = occupancy==DEPTH; empty = occupancy==0.
  - Only one command per cycle, so no simultaneous push/pop.
  - Exactly DEPTH pushes from empty succeed; push DEPTH+1 overflows.
- Sticky flags stay set until CLEAR or reset.
  - A flag set on the same cycle as another command's success is still set.
  - Success of a later command does not clear a flag.

Test Plan:
- Reset, default shift: reset; load 0x1/0x6, PUSH, POP -> responses 0F, F0, AC; POP data_out=8'h6E; STATUS=8'h04.
- Programmable shift and decrypt:
  - Stage 8'h03, SETKEY -> 8'h03.
  - Stage 'A' 8'h41, PUSH, mode 3, POP -> 8'h58 ('X').
  - mode 2, stage 'z' 8'h7A, PUSH, POP -> 8'h63 ('c').
- Bad key: stage 8'h1A, SETKEY -> 8'hEE; shift unchanged; STATUS bit5=1; CLEAR -> C1; STATUS bit5=0.
- FIFO full/wrap (DEPTH=4):
  - Push 'a','b','c','d' -> four AC; fifth PUSH -> EE; COUNT=4; STATUS full=1, ovf=1.
  - Pop four, default shift -> 6E, 6F, 70, 71.
  - Fifth POP -> 00, udf=1.
  - Push/pop 3 more, crossing the pointer wrap, preserves order.
- Non-alpha and hold:
  - Push '5' 8'h35, POP -> 8'h35 with PASS_NONALPHA=1; 8'h00 with PASS_NONALPHA=0.
  - ctl=11 for 5 cycles keeps data_out constant.
- Reset mid-operation: push 3 bytes, assert reset one cycle -> data_out=00, COUNT=00, shift back to 13, POP -> 00 with udf=1.
